// File: rtl/state_history_reader_if.sv
// Beat stream from the state history reader to its sink: word, beat index, valid/ready.
interface state_history_reader_if #(
  parameter int bits = 1
);
  logic [bits-1:0] oData;
  logic [2:0]      oIdx;
  logic            oValid;
  logic            iReady;

  modport master (output oData, oIdx, oValid, input iReady);
  modport slave  (input oData, oIdx, oValid, output iReady);
endinterface

// File: rtl/state_history_reader.sv
// Snapshots the logger's state history and streams it newest-to-oldest over a valid/ready link.
// Optional macro STATE_READER_CHECKSUM_EN appends an XOR checksum beat after the oldest word.
//
// state | meaning
// IDLE  | waiting for iStart; oData keeps the last word sent
// SEND  | streaming snapshot beats, one per accepted handshake
// DONE  | single cycle: oDone pulse, oClear if requested at start
module state_history_reader #(
  parameter int bits = 1
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStart,
  input  logic            iClearAfter,
  input  logic [bits-1:0] iCurrent,
  input  logic [bits-1:0] iPrev2,
  input  logic [bits-1:0] iPrev1,
  input  logic [bits-1:0] iPrev0,
  output logic            oBusy,
  output logic            oDone,
  output logic            oClear,
  state_history_reader_if.master rd
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef STATE_READER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  state_t          state;
  logic [bits-1:0] snap_cur;
  logic [bits-1:0] snap_p2;
  logic [bits-1:0] snap_p1;
  logic [bits-1:0] snap_p0;
  logic            clr_flag;
  logic [2:0]      idx_next;
  logic [bits-1:0] next_word;

  assign idx_next = rd.oIdx + 3'd1;

  // Word for the beat after the current one; beat 0 is loaded straight from iCurrent.
  always_comb begin
    next_word = '0;
    case (idx_next)
      3'd1:    next_word = snap_p2;
      3'd2:    next_word = snap_p1;
      3'd3:    next_word = snap_p0;
`ifdef STATE_READER_CHECKSUM_EN
      3'd4:    next_word = snap_cur ^ snap_p2 ^ snap_p1 ^ snap_p0;
`endif
      default: next_word = '0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      snap_cur  <= '0;
      snap_p2   <= '0;
      snap_p1   <= '0;
      snap_p0   <= '0;
      clr_flag  <= 1'b0;
      rd.oData  <= '0;
      rd.oIdx   <= 3'd0;
      rd.oValid <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oClear    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oDone  <= 1'b0;
          oClear <= 1'b0;
          if (iStart) begin
            snap_cur  <= iCurrent;
            snap_p2   <= iPrev2;
            snap_p1   <= iPrev1;
            snap_p0   <= iPrev0;
            clr_flag  <= iClearAfter;
            rd.oData  <= iCurrent;
            rd.oIdx   <= 3'd0;
            rd.oValid <= 1'b1;
            oBusy     <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (rd.oValid && rd.iReady) begin
            if (rd.oIdx == LAST_IDX) begin
              rd.oValid <= 1'b0;
              oDone     <= 1'b1;
              oClear    <= clr_flag;
              state     <= DONE;
            end else begin
              rd.oIdx  <= idx_next;
              rd.oData <= next_word;
            end
          end
        end
        DONE: begin
          oDone  <= 1'b0;
          oClear <= 1'b0;
          oBusy  <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          rd.oValid <= 1'b0;
          oBusy     <= 1'b0;
          oDone     <= 1'b0;
          oClear    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
